// File: rtl/addr_data_pipe_pkg.sv
// Shared types and helpers for the addr/data register-slice pipeline.
package addr_data_pipe_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } ad_t;

  // Occupancy counts 0..2*stages inclusive.
  function automatic int occ_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/addr_data_pipe_if.sv
// Valid/ready address+data channel; master drives the entry, slave drives ready.
interface addr_data_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/addr_data_skid_stage.sv
// One full-throughput skid-buffer stage: main register plus one skid entry,
// ready is registered so no combinational path runs from o_ready to i_ready.
module addr_data_skid_stage
  import addr_data_pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              m_vld;
  logic              s_vld;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              push;
  logic              pop;

  assign i_ready = !s_vld;
  assign o_valid = m_vld;
  assign push    = i_valid && !s_vld;
  assign pop     = m_vld && o_ready;

  // Skid always refills main before new input so ordering stays FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      o_addr <= '0;
      o_data <= '0;
      s_addr <= '0;
      s_data <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (!m_vld || pop) begin
      if (s_vld) begin
        m_vld  <= 1'b1;
        o_addr <= s_addr;
        o_data <= s_data;
        s_vld  <= 1'b0;
      end else if (push) begin
        m_vld  <= 1'b1;
        o_addr <= i_addr;
        o_data <= i_data;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (push) begin
      s_vld  <= 1'b1;
      s_addr <= i_addr;
      s_data <= i_data;
    end
  end

endmodule

// File: rtl/addr_data_pipe.sv
// Parametrised chain of skid-buffer stages for an addr/data pair, with a
// registered occupancy count of all held entries.
module addr_data_pipe
  import addr_data_pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  addr_data_pipe_if.slave            up,
  addr_data_pipe_if.master           dn,
  output logic [occ_w(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = occ_w(STAGES);

  if (STAGES < 1) begin : g_bad_stages
    $error("addr_data_pipe: STAGES must be >= 1");
  end

  logic              v [STAGES+1];
  logic              r [STAGES+1];
  logic [ADDR_W-1:0] a [STAGES+1];
  logic [DATA_W-1:0] d [STAGES+1];
  logic              started;
  logic              in_xfer;
  logic              out_xfer;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) started <= 1'b0;
    else      started <= 1'b1;
  end

  assign v[0]      = up.valid && started && !flush;
  assign a[0]      = up.addr;
  assign d[0]      = up.data;
  assign up.ready  = started && !flush && r[0];

  assign dn.valid  = v[STAGES];
  assign dn.addr   = a[STAGES];
  assign dn.data   = d[STAGES];
  assign r[STAGES] = dn.ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addr_data_skid_stage #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .i_valid(v[k]),
      .i_ready(r[k]),
      .i_addr (a[k]),
      .i_data (d[k]),
      .o_valid(v[k+1]),
      .o_ready(r[k+1]),
      .o_addr (a[k+1]),
      .o_data (d[k+1])
    );
  end

  assign in_xfer  = up.valid && up.ready;
  assign out_xfer = dn.valid && dn.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_addr_data_pipe.sv
// Bench: directed checks on a 2-stage pipe plus random traffic on 1- and 3-stage pipes,
// all scored against an in-order queue model of accepted entries.
module tb_addr_data_pipe;
  import addr_data_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d_iv, d_ordy, d_flush;
  logic [31:0] d_ia, d_id;
  logic        d_en_occ, d_en_ir, d_en_ov, d_en_z, d_en_pop, d_en_bound;
  logic        d_ir, d_ov;
  int          d_occ, d_pop;

  logic [2:0]  s_iv, s_ir, s_ov, s_or, s_fl;
  logic [31:0] s_ia [3];
  logic [31:0] s_id [3];
  logic [31:0] s_oa [3];
  logic [31:0] s_od [3];
  int          s_occ [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    addr_data_pipe_if #(.ADDR_W(32), .DATA_W(32)) up ();
    addr_data_pipe_if #(.ADDR_W(32), .DATA_W(32)) dn ();
    logic                   flsh;
    logic [occ_w(ST)-1:0]   occ;

    addr_data_pipe #(.ADDR_W(32), .DATA_W(32), .STAGES(ST)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flsh),
      .up       (up),
      .dn       (dn),
      .occupancy(occ)
    );

    assign s_iv[g]  = up.valid;
    assign s_ir[g]  = up.ready;
    assign s_ia[g]  = up.addr;
    assign s_id[g]  = up.data;
    assign s_ov[g]  = dn.valid;
    assign s_or[g]  = dn.ready;
    assign s_oa[g]  = dn.addr;
    assign s_od[g]  = dn.data;
    assign s_fl[g]  = flsh;
    assign s_occ[g] = int'(occ);

    if (g == 0) begin : g_dir
      assign up.valid = d_iv;
      assign up.addr  = d_ia;
      assign up.data  = d_id;
      assign dn.ready = d_ordy;
      assign flsh     = d_flush;
    end else begin : g_rnd
      logic        iv, ordy, fl, done;
      logic [31:0] ia, id;
      assign up.valid = iv;
      assign up.addr  = ia;
      assign up.data  = id;
      assign dn.ready = ordy;
      assign flsh     = fl;

      initial begin
        int   pct;
        logic acc;
        iv = 1'b0; ordy = 1'b0; fl = 1'b0; ia = '0; id = '0; done = 1'b0; pct = 50;
        void'($urandom(100 + g));
        for (int c = 0; c < 10000; c++) begin
          @(negedge clk);
          acc = iv && up.ready;
          @(posedge clk);
          #1;
          if (c % 256 == 0) pct = $urandom_range(10, 95);
          // entry may only change once accepted (or when none is offered)
          if (!iv || acc) begin
            iv = ($urandom_range(0, 99) < pct);
            ia = $urandom;
            id = $urandom;
          end
          ordy = ($urandom_range(0, 99) < (105 - pct));
          fl   = ($urandom_range(0, 199) == 0);
        end
        iv = 1'b0; fl = 1'b0; ordy = 1'b1;
        repeat (8) @(posedge clk);
        done = 1'b1;
      end
    end
  end

  ad_t  sbq [3][$];
  int   pops [3] = '{0, 0, 0};
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  logic to_flag = 1'b0;
  logic fin_ack = 1'b0;
  logic fin_req;

  task automatic chk(input string nm, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    ad_t e;
    if (d_en_occ) chk("occupancy", s_occ[0], d_occ);
    if (d_en_ir)  chk("in_ready", s_ir[0], d_ir);
    if (d_en_ov)  chk("out_valid", s_ov[0], d_ov);
    if (d_en_z) begin
      chk("out_addr_reset", s_oa[0], 0);
      chk("out_data_reset", s_od[0], 0);
    end
    if (d_en_pop) chk("pop_count", pops[0], d_pop);
    if (d_en_bound && rst) chk("occ_bound", s_occ[0] <= 4, 1);

    for (int g = 0; g < 3; g++) begin
      if (!rst) begin
        sbq[g].delete();
      end else begin
        chk($sformatf("occ_model%0d", g), s_occ[g], sbq[g].size());
        if (s_fl[g]) begin
          chk($sformatf("flush_in_ready%0d", g), s_ir[g], 0);
          sbq[g].delete();
        end else begin
          if (s_ov[g] && s_or[g]) begin
            if (sbq[g].size() == 0) begin
              chk($sformatf("spurious_out_valid%0d", g), s_ov[g], 0);
            end else begin
              e = sbq[g].pop_front();
              chk($sformatf("out_addr%0d", g), s_oa[g], e.addr);
              chk($sformatf("out_data%0d", g), s_od[g], e.data);
              pops[g]++;
            end
          end
          if (s_iv[g] && s_ir[g]) begin
            e.addr = s_ia[g];
            e.data = s_id[g];
            sbq[g].push_back(e);
          end
        end
      end
    end

    if (!fin_req && !to_flag && cyc >= 20000) begin
      nvec++;
      nerr++;
      $display("FAIL timeout: cycle %0d reached without random runs completing", cyc);
      to_flag = 1'b1;
    end
    if (fin_req && !fin_ack) begin
      for (int g = 1; g < 3; g++) begin
        chk($sformatf("rnd_progress%0d", g), pops[g] > 500, 1);
        chk($sformatf("rnd_drained%0d", g), sbq[g].size(), 0);
      end
      fin_ack = 1'b1;
    end
    cyc++;
  end

  int sj;
  int exp_pop;

  task automatic tick();
    @(posedge clk);
    #1;
    d_en_occ = 0; d_en_ir = 0; d_en_ov = 0; d_en_z = 0; d_en_pop = 0;
  endtask

  task automatic send_until(input int last, input int maxc, input logic [31:0] ab,
                            input logic [31:0] db);
    int   c;
    logic acc;
    c = 0;
    while (sj < last && c < maxc) begin
      d_iv = 1'b1;
      d_ia = ab + 32'(sj);
      d_id = db + 32'(sj);
      @(negedge clk);
      acc = s_ir[0];
      tick();
      c++;
      if (acc) sj++;
    end
  endtask

  initial begin
    rst = 1'b0; d_iv = 0; d_ordy = 0; d_flush = 0; d_ia = '0; d_id = '0;
    d_en_occ = 0; d_en_ir = 0; d_en_ov = 0; d_en_z = 0; d_en_pop = 0; d_en_bound = 0;
    d_ir = 0; d_ov = 0; d_occ = 0; d_pop = 0; fin_req = 0; sj = 0; exp_pop = 0;

    // power-up reset, then release
    tick();
    d_en_ov = 1; d_ov = 0; d_en_z = 1; d_en_occ = 1; d_occ = 0; d_en_ir = 1; d_ir = 0;
    tick();
    rst = 1'b1;
    d_en_ir = 1; d_ir = 0;
    tick();
    d_en_ir = 1; d_ir = 1; d_en_occ = 1; d_occ = 0;

    // streaming, out_ready held high
    d_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      d_iv = 1'b1; d_ia = 32'h100 + 32'(i); d_id = 32'hA0 + 32'(i);
      d_en_ir = 1; d_ir = 1;
      if (i == 1) begin d_en_ov = 1; d_ov = 0; end
      if (i == 2) begin d_en_ov = 1; d_ov = 1; end
    end
    tick();
    d_iv = 1'b0;
    repeat (3) tick();
    exp_pop += 8;
    d_en_occ = 1; d_occ = 0; d_en_pop = 1; d_pop = exp_pop;

    // backpressure: only four fit
    tick();
    sj = 0; d_ordy = 1'b0;
    send_until(6, 10, 32'h200, 32'hB0);
    d_en_occ = 1; d_occ = 4; d_en_ir = 1; d_ir = 0;
    tick();
    d_ordy = 1'b1;
    send_until(6, 20, 32'h200, 32'hB0);
    d_iv = 1'b0;
    repeat (6) tick();
    exp_pop += 6;
    d_en_occ = 1; d_occ = 0; d_en_pop = 1; d_pop = exp_pop;

    // push and pop together starting from full
    tick();
    sj = 0; d_ordy = 1'b0;
    send_until(4, 10, 32'h300, 32'hC0);
    d_en_bound = 1'b1;
    d_iv = 1'b1; d_ia = 32'h304; d_id = 32'hC4; d_ordy = 1'b1;
    d_en_occ = 1; d_occ = 4; d_en_ir = 1; d_ir = 0;
    tick();
    d_en_occ = 1; d_occ = 3; d_en_ir = 1; d_ir = 0;
    tick();
    d_en_occ = 1; d_occ = 2; d_en_ir = 1; d_ir = 1;
    send_until(10, 20, 32'h300, 32'hC0);
    d_iv = 1'b0;
    repeat (6) tick();
    exp_pop += 10;
    d_en_occ = 1; d_occ = 0; d_en_pop = 1; d_pop = exp_pop;
    d_en_bound = 1'b0;

    // flush with three entries held and both handshakes offered
    tick();
    sj = 0; d_ordy = 1'b0;
    send_until(3, 10, 32'h400, 32'hD0);
    d_iv = 1'b1; d_ia = 32'h4AA; d_id = 32'hDAA; d_ordy = 1'b1; d_flush = 1'b1;
    d_en_ir = 1; d_ir = 0; d_en_occ = 1; d_occ = 3;
    tick();
    d_flush = 1'b0; d_iv = 1'b0;
    d_en_occ = 1; d_occ = 0; d_en_ov = 1; d_ov = 0; d_en_ir = 1; d_ir = 1;
    tick();
    d_iv = 1'b1; d_ia = 32'h55; d_id = 32'hDEAD;
    tick();
    d_iv = 1'b0;
    d_en_ov = 1; d_ov = 0; d_en_occ = 1; d_occ = 1;
    tick();
    d_en_ov = 1; d_ov = 1;
    repeat (3) tick();
    exp_pop += 1;
    d_en_occ = 1; d_occ = 0; d_en_pop = 1; d_pop = exp_pop;

    // reset in the middle of traffic
    tick();
    sj = 0; d_ordy = 1'b0;
    send_until(2, 10, 32'h500, 32'hE0);
    d_iv = 1'b0;
    d_en_ov = 1; d_ov = 1;
    tick();
    rst = 1'b0;
    d_en_ov = 1; d_ov = 0; d_en_z = 1; d_en_occ = 1; d_occ = 0; d_en_ir = 1; d_ir = 0;
    tick();
    d_en_ov = 1; d_ov = 0; d_en_z = 1; d_en_occ = 1; d_occ = 0; d_en_ir = 1; d_ir = 0;
    tick();
    rst = 1'b1;
    d_en_ir = 1; d_ir = 0;
    tick();
    d_en_ir = 1; d_ir = 1; d_en_occ = 1; d_occ = 0; d_en_pop = 1; d_pop = exp_pop;
    tick();

    wait ((g_dut[1].g_rnd.done && g_dut[2].g_rnd.done) || to_flag);
    fin_req = 1'b1;
    wait (fin_ack);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
